// File: rtl/mojo_pkg.sv
// Shared definitions for the Mojo board logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: repeat-FSM state encoding, board clock rate, small elaboration helpers.
package mojo_pkg;

  // Auto-repeat FSM states. Encodings are fixed so other blocks and debug
  // probes can decode them directly.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rp_state_t;

  // Board oscillator frequency.
  localparam int CLK_HZ = 50_000_000;

  // Larger of two integers; used to size counters shared by two terminal counts.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle between the button pin and its consumers (LED counter enable etc).
// Latency: n/a (wires only).
// Backpressure: none; all outputs are single-cycle events or levels.
// Signals:
//   btn_in        raw asynchronous button pin
//   level         debounced state, 1 = pressed
//   press         1-cycle pulse on debounced 0->1
//   release_pulse 1-cycle pulse on debounced 1->0 ("release" is a reserved word)
//   step          1-cycle pulse on press and on each auto-repeat
//   holding       1 while the button has been held past the repeat delay
interface button_conditioner_if;

  logic btn_in;
  logic level;
  logic press;
  logic release_pulse;
  logic step;
  logic holding;

  // Conditioner side: samples the pin, drives the events.
  modport master (
    input  btn_in,
    output level,
    output press,
    output release_pulse,
    output step,
    output holding
  );

  // Consumer side: owns the pin, observes the events.
  modport slave (
    output btn_in,
    input  level,
    input  press,
    input  release_pulse,
    input  step,
    input  holding
  );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// Latency: STAGES clocks from d to q.
// Backpressure: none.
// Ports: clk, rst (sync, active-high, loads INIT into every flop), d (async in), q (synced out).
module bit_synchronizer #(
  parameter int STAGES = 2,
  parameter bit INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Reset to the line's idle value so no spurious edge is seen after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= {STAGES{INIT}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Turns a bouncy asynchronous push-button into clean single-cycle events with hold-to-repeat.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES clocks from a clean pin edge to level/press/release/step.
// Backpressure: none; consumers must accept every pulse.
// Ports: clk, rst (sync, active-high), bus (button_conditioner_if.master: btn_in in;
//        level, press, release_pulse, step, holding out).
module button_conditioner
  import mojo_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  button_conditioner_if.master  bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RP_MAX = max_int(REPEAT_DELAY, REPEAT_RATE);
  localparam int RP_W   = $clog2(RP_MAX);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

  // Pin value when the button is not pressed.
  localparam bit IDLE_PIN = (ACTIVE_LOW != 0);

  // ---------------------------------------------------------------------------
  // Synchronizer. The raw pin is synchronized (reset to its idle value) and
  // then polarity-corrected, so s is always 1 = pressed.
  // ---------------------------------------------------------------------------
  logic pin_sync;
  logic s;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES),
    .INIT   (IDLE_PIN)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_in),
    .q   (pin_sync)
  );

  assign s = pin_sync ^ IDLE_PIN;

  // ---------------------------------------------------------------------------
  // Debounce and edge detect. The counter only advances while s disagrees
  // with level, and any agreement clears it, so a glitch shorter than
  // DEBOUNCE_CYCLES restarts the count. It clears on acceptance, so it never
  // needs to saturate or wrap.
  // ---------------------------------------------------------------------------
  logic            level_q;
  logic [DB_W-1:0] db_cnt;
  logic            db_flip;
  logic            press_nxt;
  logic            release_nxt;
  logic            press_q;
  logic            release_q;

  assign db_flip     = (s != level_q) && (db_cnt == DB_LAST);
  assign press_nxt   = db_flip &&  s;
  assign release_nxt = db_flip && !s;

  // press/release are computed from the same condition that flips level, so
  // they land in the same cycle as the level change and are mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= 1'b0;
      db_cnt    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      if (s == level_q) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        level_q <= s;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      press_q   <= press_nxt;
      release_q <= release_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat FSM. It consumes the pre-register press/release terms so the
  // first step coincides with the press pulse, and so a release that is
  // accepted on a terminal-count cycle suppresses that step.
  // ---------------------------------------------------------------------------
  rp_state_t       state;
  rp_state_t       state_nxt;
  logic [RP_W-1:0] rp_cnt;
  logic [RP_W-1:0] rp_cnt_nxt;
  logic            step_nxt;
  logic            step_q;
  logic            holding_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rp_cnt    <= '0;
      step_q    <= 1'b0;
      holding_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rp_cnt    <= rp_cnt_nxt;
      step_q    <= step_nxt;
      holding_q <= (state_nxt == ST_REPEAT);
    end
  end

  always_comb begin
    state_nxt  = state;
    rp_cnt_nxt = rp_cnt;
    step_nxt   = 1'b0;

    if (REPEAT_EN == 0) begin
      // Repeat disabled: one step per press, FSM parked.
      state_nxt  = ST_IDLE;
      rp_cnt_nxt = '0;
      step_nxt   = press_nxt;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press_nxt) begin
            state_nxt  = ST_DELAY;
            rp_cnt_nxt = '0;
            step_nxt   = 1'b1;
          end
        end

        ST_DELAY: begin
          // Release has priority over the delay terminal count.
          if (release_nxt || !level_q) begin
            state_nxt  = ST_IDLE;
            rp_cnt_nxt = '0;
          end else if (rp_cnt == DELAY_LAST) begin
            state_nxt  = ST_REPEAT;
            rp_cnt_nxt = '0;
            step_nxt   = 1'b1;
          end else begin
            rp_cnt_nxt = rp_cnt + RP_W'(1);
          end
        end

        ST_REPEAT: begin
          // Release has priority over the repeat terminal count.
          if (release_nxt || !level_q) begin
            state_nxt  = ST_IDLE;
            rp_cnt_nxt = '0;
          end else if (rp_cnt == RATE_LAST) begin
            rp_cnt_nxt = '0;
            step_nxt   = 1'b1;
          end else begin
            rp_cnt_nxt = rp_cnt + RP_W'(1);
          end
        end

        default: begin
          state_nxt  = ST_IDLE;
          rp_cnt_nxt = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.level         = level_q;
  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;
  assign bus.step          = step_q;
  assign bus.holding       = holding_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: one instance with auto-repeat, one without,
// both fed from the same pin and compared every cycle against a reference model.
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RR   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b1;

  always #5 clk = ~clk;

  button_conditioner_if bif_a ();
  button_conditioner_if bif_b ();

  assign bif_a.btn_in = btn;
  assign bif_b.btn_in = btn;

  button_conditioner #(
    .ACTIVE_LOW(1), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bif_a)
  );

  button_conditioner #(
    .ACTIVE_LOW(1), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
    .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bif_b)
  );

  // Output vectors: {level, press, release, step, holding}
  wire [4:0] out_a = {bif_a.level, bif_a.press, bif_a.release_pulse, bif_a.step, bif_a.holding};
  wire [4:0] out_b = {bif_b.level, bif_b.press, bif_b.release_pulse, bif_b.step, bif_b.holding};

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int st_a   = 0;
  int st_b   = 0;

  // ---------------------------------------------------------------------------
  // Reference model, index 0 = repeat enabled, 1 = repeat disabled.
  // Debounce: level follows s once s has disagreed for DB consecutive cycles.
  // Repeat: t = cycles since the press; steps at t=0, t=RD, RD+RR, RD+2RR ...
  // ---------------------------------------------------------------------------
  bit       dl    [2][SYNC];
  bit       m_lvl [2];
  int       m_run [2];
  int       m_t   [2];
  bit [4:0] m_out [2];
  bit       rep_en[2];

  task automatic model_edge(input int m, input bit r, input bit b);
    bit s_old, mp, mr, ms, mh;
    if (r) begin
      for (int i = 0; i < SYNC; i++) dl[m][i] = 1'b0;
      m_lvl[m] = 1'b0;
      m_run[m] = 0;
      m_t[m]   = -1;
      m_out[m] = 5'b0;
      return;
    end
    s_old = dl[m][SYNC-1];
    for (int i = SYNC-1; i > 0; i--) dl[m][i] = dl[m][i-1];
    dl[m][0] = ~b;
    mp = 1'b0;
    mr = 1'b0;
    if (s_old == m_lvl[m]) begin
      m_run[m] = 0;
    end else begin
      m_run[m]++;
      if (m_run[m] == DB) begin
        m_lvl[m] = s_old;
        m_run[m] = 0;
        mp = s_old;
        mr = !s_old;
      end
    end
    if (mp) begin
      m_t[m] = 0;
      ms = 1'b1;
    end else if (m_lvl[m] && m_t[m] >= 0) begin
      m_t[m]++;
      ms = rep_en[m] && (m_t[m] == RD || (m_t[m] > RD && ((m_t[m] - RD) % RR) == 0));
    end else begin
      m_t[m] = -1;
      ms = 1'b0;
    end
    mh = rep_en[m] && m_lvl[m] && (m_t[m] >= RD);
    m_out[m] = {m_lvl[m], mp, mr, ms, mh};
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b (level,press,release,step,holding)",
               name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare at negedge.
  task automatic tick(input bit r, input bit b);
    rst = r;
    btn = b;
    @(posedge clk);
    model_edge(0, r, b);
    model_edge(1, r, b);
    @(negedge clk);
    cyc++;
    if (out_a[1] === 1'b1) st_a++;
    if (out_b[1] === 1'b1) st_b++;
    check("model_repeat", out_a, m_out[0]);
    check("model_norepeat", out_b, m_out[1]);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: hold (rst, btn) for n clocks, then expect out_a.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit       r;
    bit       b;
    int       n;
    bit [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input bit b, input int n, input bit [4:0] e);
    vec_t v;
    v.r = r; v.b = b; v.n = n; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    bit rb;
    int run;

    rep_en[0] = 1'b1;
    rep_en[1] = 1'b0;

    // Reset, then quiet idle pin.
    add(1, 1, 3, 5'b00000);
    add(0, 1, 50, 5'b00000);
    // Clean 8-cycle press then release.
    add(0, 0, 5, 5'b00000);
    add(0, 0, 1, 5'b11010);
    add(0, 0, 2, 5'b10000);
    add(0, 1, 5, 5'b10000);
    add(0, 1, 1, 5'b00100);
    add(0, 1, 1, 5'b00000);
    // Bounce: 3 low / 1 high, five times; never accepted.
    for (int k = 0; k < 5; k++) begin
      add(0, 0, 3, 5'b00000);
      add(0, 1, 1, 5'b00000);
    end
    add(0, 1, 10, 5'b00000);
    // Hold 40 cycles: steps at t0, t0+10, +13, +16 ... +34, +37.
    add(0, 0, 5, 5'b00000);
    add(0, 0, 1, 5'b11010);
    add(0, 0, 9, 5'b10000);
    add(0, 0, 1, 5'b10011);
    add(0, 0, 2, 5'b10001);
    add(0, 0, 1, 5'b10011);
    add(0, 0, 2, 5'b10001);
    add(0, 0, 1, 5'b10011);
    add(0, 0, 17, 5'b10001);
    add(0, 0, 1, 5'b10011);
    // Release is accepted exactly on a repeat terminal count: no step.
    add(0, 1, 5, 5'b10001);
    add(0, 1, 1, 5'b00100);
    add(0, 1, 3, 5'b00000);

    @(negedge clk);
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].r, tbl[i].b);
      check($sformatf("vec%0d", i), out_a, tbl[i].exp);
    end
    // Press of 8 + hold of 40 -> 1 + 11 steps with repeat, 2 without.
    check_int("steps_repeat", st_a, 12);
    check_int("steps_norepeat", st_b, 2);

    // Reset pulsed while in REPEAT with the pin still held.
    repeat (20) tick(0, 0);
    check("hold_before_rst", out_a, 5'b10001);
    tick(1, 0);
    check("after_rst_a", out_a, 5'b00000);
    check("after_rst_b", out_b, 5'b00000);
    repeat (5) tick(0, 0);
    check("pre_repress", out_a, 5'b00000);
    tick(0, 0);
    check("repress_a", out_a, 5'b11010);
    check("repress_b", out_b, 5'b11010);
    repeat (6) tick(0, 1);
    check("release_after_repress", out_a, 5'b00100);
    repeat (4) tick(0, 1);

    // Random runs of pin levels with occasional resets.
    run = 0;
    while (run < 3000) begin
      int len;
      rb  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        tick(($urandom_range(0, 120) == 0), rb);
        run++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
